multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core; the driving end of the `alu_op` interface into `alu_control`.
- Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the datapath mux selects, register/PC/IR write strobes and memory handshake.
- Flags illegal opcodes and memory-bus timeouts as a sticky trap.

Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for `mem_ready` in any memory state; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  inst[6:0] from IR; valid from DECODE onward
- branch_taken  in  1  branch comparison result from datapath, valid in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- alu_op  out  3  to alu_control: 000 add, 001 branch compare, 010 R-type, 011 I-type, 100 LUI, 101 AUIPC
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1
- alu_src_b  out  2  00 rs2, 01 constant 4, 10 imm
- pc_src  out  1  0 live ALU result, 1 alu_out register
- wb_sel  out  2  00 alu_out, 01 mem_data, 10 PC
- mem_read, mem_write  out  1  memory request, held until mem_ready
- ir_write  out  1  load IR and old_pc
- pc_write  out  1  load PC
- reg_write  out  1  write rd
- instr_done  out  1  one-cycle pulse on the retiring cycle
- trap  out  1  sticky halt
- trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout

Behaviour:
- Moore FSM; all outputs are decoded from state, plus `mem_ready` / `branch_taken` where noted. Datapath captures alu_out every cycle.
- Reset (async): state=FETCH, wait counter=0, trap=0, trap_cause=00. While reset is high, every strobe (mem_read, mem_write, ir_write, pc_write, reg_write, instr_done) is forced to 0; selects take their FETCH values.
- Outputs not listed for a state are 0.
- FETCH: mem_read=1, a=00, b=01, alu_op=000.
  - mem_ready=1: ir_write=1 and pc_write=1 (pc_src=0, PC<=PC+4); go to DECODE.
  - Otherwise stay.
- DECODE: a=01, b=10, alu_op=000 (target old_pc+imm into alu_out). Dispatch on opcode:
  - 0110011 -> EXEC_R; 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR
  - 0110111 -> LUI; 0010111 -> AUIPC
  - any other opcode -> TRAP with cause 01
- EXEC_R: a=10, b=00, alu_op=010; go to ALU_WB.
- EXEC_I: a=10, b=10, alu_op=011; go to ALU_WB.
- LUI: b=10, alu_op=100; go to ALU_WB.
- AUIPC: a=01, b=10, alu_op=101; go to ALU_WB.
- ALU_WB: reg_write=1, wb_sel=00, instr_done=1; go to FETCH.
- MEM_ADDR: a=10, b=10, alu_op=000. Go to MEM_RD if opcode is a load, else MEM_WR.
- MEM_RD: mem_read=1; on mem_ready go to LOAD_WB.
- LOAD_WB: reg_write=1, wb_sel=01, instr_done=1; go to FETCH.
- MEM_WR: mem_write=1; on mem_ready assert instr_done=1 and go to FETCH.
- BRANCH: a=10, b=00, alu_op=001, pc_src=1, pc_write=branch_taken, instr_done=1; go to FETCH.
- JAL: reg_write=1, wb_sel=10 (PC already holds PC+4), pc_write=1, pc_src=1, instr_done=1; go to FETCH.
- JALR: a=10, b=10, alu_op=000, pc_src=0, pc_write=1, reg_write=1, wb_sel=10, instr_done=1; go to FETCH.
  - rd==rs1 is safe: registers are read before the edge.
  - The datapath clears the target LSB.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD and MEM_WR; increments each cycle those states wait with mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP with cause 10, and drop the request the same edge.
  - mem_ready on the limit cycle wins over the timeout.
- TRAP: all strobes 0, trap=1, cause held; exit only via reset.
- Reset mid-instruction: state aborts immediately; no partial strobe is issued after the reset edge.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB. alu_op=010 in cycle 3; reg_write and instr_done in cycle 4; 4 cycles per instruction.
- LW with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles; LOAD_WB wb_sel=01; total 8 cycles. SW with immediate ready -> 4 cycles, mem_write 1 cycle, no reg_write.
- BEQ with branch_taken=1 then =0 -> pc_write=1 with pc_src=1 first time, pc_write=0 second time; alu_op=001; 3 cycles each.
- JAL / JALR / LUI / AUIPC -> wb_sel=10 with pc_write for both jumps; alu_op=100 for LUI and 101 for AUIPC.
- Opcode 0000000 -> trap=1, trap_cause=01 after DECODE; all strobes stay 0 for 20 cycles; async reset returns to FETCH with trap=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> trap_cause=10 after 4 wait cycles and mem_read deasserts. Repeat with mem_ready=1 on the 4th wait cycle -> no trap, DECODE entered.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multi-cycle RV32I core. Sequences each
//            instruction through fetch/decode/execute/memory/writeback,
//            drives datapath selects and strobes, and raises a sticky trap.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_src,
    output logic [1:0] wb_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_EXEC_R   = 4'd2;
    localparam logic [3:0] c_EXEC_I   = 4'd3;
    localparam logic [3:0] c_LUI      = 4'd4;
    localparam logic [3:0] c_AUIPC    = 4'd5;
    localparam logic [3:0] c_ALU_WB   = 4'd6;
    localparam logic [3:0] c_MEM_ADDR = 4'd7;
    localparam logic [3:0] c_MEM_RD   = 4'd8;
    localparam logic [3:0] c_LOAD_WB  = 4'd9;
    localparam logic [3:0] c_MEM_WR   = 4'd10;
    localparam logic [3:0] c_BRANCH   = 4'd11;
    localparam logic [3:0] c_JAL      = 4'd12;
    localparam logic [3:0] c_JALR     = 4'd13;
    localparam logic [3:0] c_TRAP     = 4'd14;

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause;
    logic             w_mem_state;
    logic             w_timeout;

    logic [2:0] w_alu_op;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_wb_sel;
    logic       w_pc_src;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic       w_instr_done;

    assign w_mem_state = (r_state == c_FETCH) || (r_state == c_MEM_RD) ||
                         (r_state == c_MEM_WR);
    assign w_cnt_inc   = r_cnt + 1'b1;
    // Fires on the wait cycle whose increment would hit the limit; a ready
    // on that same cycle still completes the access.
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready &&
                         (w_cnt_inc == c_TIMEOUT);

    always_comb begin
        w_next       = r_state;
        w_cause      = r_cause;
        w_alu_op     = 3'b000;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        w_wb_sel     = 2'b00;
        w_pc_src     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_read = 1'b1;
                w_src_b    = 2'b01;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = c_DECODE;
                end else if (w_timeout) begin
                    w_next  = c_TRAP;
                    w_cause = 2'b10;
                end
            end
            c_DECODE: begin
                w_src_a = 2'b01;
                w_src_b = 2'b10;
                case (opcode)
                    c_OP_R:      w_next = c_EXEC_R;
                    c_OP_I:      w_next = c_EXEC_I;
                    c_OP_LOAD,
                    c_OP_STORE:  w_next = c_MEM_ADDR;
                    c_OP_BRANCH: w_next = c_BRANCH;
                    c_OP_JAL:    w_next = c_JAL;
                    c_OP_JALR:   w_next = c_JALR;
                    c_OP_LUI:    w_next = c_LUI;
                    c_OP_AUIPC:  w_next = c_AUIPC;
                    default: begin
                        w_next  = c_TRAP;
                        w_cause = 2'b01;
                    end
                endcase
            end
            c_EXEC_R: begin
                w_src_a  = 2'b10;
                w_alu_op = 3'b010;
                w_next   = c_ALU_WB;
            end
            c_EXEC_I: begin
                w_src_a  = 2'b10;
                w_src_b  = 2'b10;
                w_alu_op = 3'b011;
                w_next   = c_ALU_WB;
            end
            c_LUI: begin
                w_src_b  = 2'b10;
                w_alu_op = 3'b100;
                w_next   = c_ALU_WB;
            end
            c_AUIPC: begin
                w_src_a  = 2'b01;
                w_src_b  = 2'b10;
                w_alu_op = 3'b101;
                w_next   = c_ALU_WB;
            end
            c_ALU_WB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_MEM_ADDR: begin
                w_src_a = 2'b10;
                w_src_b = 2'b10;
                w_next  = (opcode == c_OP_LOAD) ? c_MEM_RD : c_MEM_WR;
            end
            c_MEM_RD: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_next = c_LOAD_WB;
                end else if (w_timeout) begin
                    w_next  = c_TRAP;
                    w_cause = 2'b10;
                end
            end
            c_LOAD_WB: begin
                w_reg_write  = 1'b1;
                w_wb_sel     = 2'b01;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_MEM_WR: begin
                w_mem_write = 1'b1;
                if (mem_ready) begin
                    w_instr_done = 1'b1;
                    w_next       = c_FETCH;
                end else if (w_timeout) begin
                    w_next  = c_TRAP;
                    w_cause = 2'b10;
                end
            end
            c_BRANCH: begin
                w_src_a      = 2'b10;
                w_alu_op     = 3'b001;
                w_pc_src     = 1'b1;
                w_pc_write   = branch_taken;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_JAL: begin
                w_reg_write  = 1'b1;
                w_wb_sel     = 2'b10;
                w_pc_write   = 1'b1;
                w_pc_src     = 1'b1;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_JALR: begin
                w_src_a      = 2'b10;
                w_src_b      = 2'b10;
                w_pc_write   = 1'b1;
                w_reg_write  = 1'b1;
                w_wb_sel     = 2'b10;
                w_instr_done = 1'b1;
                w_next       = c_FETCH;
            end
            c_TRAP: begin
                w_next = c_TRAP;
            end
            default: begin
                w_next = c_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_FETCH;
            r_cnt   <= '0;
            r_cause <= 2'b00;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            // Counts only while parked in a memory state; any transition clears it.
            if (w_mem_state && !mem_ready && (w_next == r_state)) begin
                r_cnt <= w_cnt_inc;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign alu_op     = w_alu_op;
    assign alu_src_a  = w_src_a;
    assign alu_src_b  = w_src_b;
    assign pc_src     = w_pc_src;
    assign wb_sel     = w_wb_sel;
    // Strobes are masked combinationally so nothing leaks while reset is high.
    assign mem_read   = w_mem_read   & ~reset;
    assign mem_write  = w_mem_write  & ~reset;
    assign ir_write   = w_ir_write   & ~reset;
    assign pc_write   = w_pc_write   & ~reset;
    assign reg_write  = w_reg_write  & ~reset;
    assign instr_done = w_instr_done & ~reset;
    assign trap       = (r_state == c_TRAP);
    assign trap_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench: directed vector table plus random
//            instruction stream compared against a per-instruction trace model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_op;
    logic [1:0] alu_src_a, alu_src_b, wb_sel, trap_cause;
    logic       pc_src, mem_read, mem_write, ir_write, pc_write, reg_write;
    logic       instr_done, trap;

    multicycle_control #(.MEM_TIMEOUT(T), .CNT_W(3)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .wb_sel(wb_sel), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .instr_done(instr_done), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] a;
        logic [1:0] b;
        logic       pc_src;
        logic [1:0] wb;
        logic       mr, mw, irw, pcw, rw, done, trap;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        logic rdy;
        logic tk;
        out_t exp;
    } cyc_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       tk;
        int         cycles;
        logic [1:0] cause;
    } vec_t;

    cyc_t q[$];
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;
    bit   model_trapped;

    function automatic out_t sample();
        out_t s;
        s.alu_op = alu_op;  s.a = alu_src_a; s.b = alu_src_b;
        s.pc_src = pc_src;  s.wb = wb_sel;   s.mr = mem_read;
        s.mw = mem_write;   s.irw = ir_write; s.pcw = pc_write;
        s.rw = reg_write;   s.done = instr_done; s.trap = trap;
        s.cause = trap_cause;
        return s;
    endfunction

    task automatic chk_out(input string nm, input int cyc, input out_t exp);
        out_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", nm, got, exp);
        end
    endtask

    // ---------------- reference trace model ----------------
    function automatic void push(input logic rdy, input logic tk, input out_t o);
        cyc_t c;
        c.rdy = rdy; c.tk = tk; c.exp = o;
        q.push_back(c);
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic out_t mk(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        out_t o;
        o = '0;
        o.alu_op = op; o.a = a; o.b = b;
        return o;
    endfunction

    // A memory access: up to T-1 idle cycles are tolerated, the T-th idle one traps.
    function automatic bit mem_phase(input out_t wait_o, input out_t ready_o, input int w);
        if (w >= T) begin
            for (int k = 0; k < T; k++) push(1'b0, rnd(), wait_o);
            return 1'b1;
        end
        for (int k = 0; k < w; k++) push(1'b0, rnd(), wait_o);
        push(1'b1, rnd(), ready_o);
        return 1'b0;
    endfunction

    function automatic void trap_tail(input logic [1:0] cause, input int n);
        out_t o;
        o = '0; o.trap = 1'b1; o.cause = cause;
        for (int k = 0; k < n; k++) push(rnd(), rnd(), o);
    endfunction

    function automatic void build(input logic [6:0] op, input int fw, input int mw,
                                  input logic tk, input int tail);
        out_t w, r;
        q.delete();
        model_trapped = 1'b0;
        w = mk(3'b000, 2'b00, 2'b01); w.mr = 1'b1;
        r = w; r.irw = 1'b1; r.pcw = 1'b1;
        if (mem_phase(w, r, fw)) begin
            model_trapped = 1'b1; trap_tail(2'b10, tail); return;
        end
        push(rnd(), rnd(), mk(3'b000, 2'b01, 2'b10));
        r = '0; r.rw = 1'b1; r.done = 1'b1;   // generic ALU writeback
        case (op)
            7'b0110011: begin push(rnd(), rnd(), mk(3'b010, 2'b10, 2'b00)); push(rnd(), rnd(), r); end
            7'b0010011: begin push(rnd(), rnd(), mk(3'b011, 2'b10, 2'b10)); push(rnd(), rnd(), r); end
            7'b0110111: begin push(rnd(), rnd(), mk(3'b100, 2'b00, 2'b10)); push(rnd(), rnd(), r); end
            7'b0010111: begin push(rnd(), rnd(), mk(3'b101, 2'b01, 2'b10)); push(rnd(), rnd(), r); end
            7'b0000011, 7'b0100011: begin
                out_t mwait, mdone;
                push(rnd(), rnd(), mk(3'b000, 2'b10, 2'b10));
                mwait = '0;
                if (op == 7'b0000011) mwait.mr = 1'b1; else mwait.mw = 1'b1;
                mdone = mwait;
                if (op == 7'b0100011) mdone.done = 1'b1;
                if (mem_phase(mwait, mdone, mw)) begin
                    model_trapped = 1'b1; trap_tail(2'b10, tail); return;
                end
                if (op == 7'b0000011) begin
                    r.wb = 2'b01; push(rnd(), rnd(), r);
                end
            end
            7'b1100011: begin
                out_t o;
                o = mk(3'b001, 2'b10, 2'b00); o.pc_src = 1'b1; o.pcw = tk; o.done = 1'b1;
                push(rnd(), tk, o);
            end
            7'b1101111: begin
                r.wb = 2'b10; r.pcw = 1'b1; r.pc_src = 1'b1; push(rnd(), rnd(), r);
            end
            7'b1100111: begin
                out_t o;
                o = mk(3'b000, 2'b10, 2'b10); o.pcw = 1'b1; o.rw = 1'b1; o.wb = 2'b10; o.done = 1'b1;
                push(rnd(), rnd(), o);
            end
            default: begin
                model_trapped = 1'b1; trap_tail(2'b01, tail);
            end
        endcase
    endfunction

    // ---------------- drivers ----------------
    // All tasks start and finish exactly on a falling clock edge.
    task automatic run_q(input string nm, input int limit, output int done_at);
        int n;
        done_at = 0;
        n = (limit < q.size()) ? limit : q.size();
        for (int i = 0; i < n; i++) begin
            mem_ready = q[i].rdy; branch_taken = q[i].tk;
            #1;
            chk_out(nm, i, q[i].exp);
            if (done_at == 0 && instr_done === 1'b1) done_at = i + 1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk_out(nm, 0, mk(3'b000, 2'b00, 2'b01));
        @(negedge clk);
        #1;
        chk_out(nm, 1, mk(3'b000, 2'b00, 2'b01));
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
    endtask

    function automatic void add_vec(input string n, input logic [6:0] op, input int fw,
                                    input int mw, input logic tk, input int cyc,
                                    input logic [1:0] cause);
        vec_t v;
        v.name = n; v.op = op; v.fw = fw; v.mw = mw; v.tk = tk;
        v.cycles = cyc; v.cause = cause;
        vecs.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        logic [6:0] legal [9];
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        add_vec("add",        7'b0110011, 0, 0, 1'b0, 4, 2'b00);
        add_vec("addi",       7'b0010011, 0, 0, 1'b0, 4, 2'b00);
        add_vec("lw_wait3",   7'b0000011, 0, 3, 1'b0, 8, 2'b00);
        add_vec("sw",         7'b0100011, 0, 0, 1'b0, 4, 2'b00);
        add_vec("sw_wait3",   7'b0100011, 0, 3, 1'b0, 7, 2'b00);
        add_vec("beq_taken",  7'b1100011, 0, 0, 1'b1, 3, 2'b00);
        add_vec("beq_not",    7'b1100011, 0, 0, 1'b0, 3, 2'b00);
        add_vec("jal",        7'b1101111, 0, 0, 1'b0, 3, 2'b00);
        add_vec("jalr",       7'b1100111, 0, 0, 1'b0, 3, 2'b00);
        add_vec("lui",        7'b0110111, 0, 0, 1'b0, 4, 2'b00);
        add_vec("auipc",      7'b0010111, 0, 0, 1'b0, 4, 2'b00);
        add_vec("fetch_edge", 7'b0110011, 3, 0, 1'b0, 7, 2'b00);
        add_vec("fetch_to",   7'b0110011, 4, 0, 1'b0, 0, 2'b10);
        add_vec("lw_to",      7'b0000011, 0, 4, 1'b0, 0, 2'b10);
        add_vec("sw_to",      7'b0100011, 0, 5, 1'b0, 0, 2'b10);
        add_vec("illegal",    7'b0000000, 0, 0, 1'b0, 0, 2'b01);

        @(negedge clk);
        do_reset("reset_init");

        foreach (vecs[i]) begin
            opcode = vecs[i].op;
            build(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].tk, 20);
            run_q(vecs[i].name, q.size(), d);
            chk_int({vecs[i].name, "_cycles"}, d, vecs[i].cycles);
            checks++;
            if (trap_cause !== vecs[i].cause) begin
                failures++;
                $display("FAIL %s_cause got=%b required=%b", vecs[i].name, trap_cause, vecs[i].cause);
            end
            if (model_trapped) do_reset({vecs[i].name, "_reset"});
        end

        // Reset asserted while a load waits in the memory state.
        opcode = 7'b0000011;
        build(7'b0000011, 0, 3, 1'b0, 0);
        run_q("lw_abort", 5, d);
        do_reset("abort_reset");
        opcode = 7'b0110011;
        build(7'b0110011, 0, 0, 1'b0, 0);
        run_q("add_after_abort", q.size(), d);
        chk_int("add_after_abort_cycles", d, 4);

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            int fw, mw;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal[$urandom_range(0, 8)];
            fw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 11) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            opcode = op;
            build(op, fw, mw, rnd(), 3);
            run_q("rand", q.size(), d);
            if (model_trapped) do_reset("rand_reset");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
